// File: rtl/game_pkg.sv
// game_pkg: shared encodings for the game referee.
//   - state encoding (ST_IDLE/ST_PLAY/ST_PAUSE/ST_MATCH_OVER)
//   - winner codes (WIN_NONE/WIN_P1/WIN_P2)
//   - score width and saturation value
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PLAY       = 2'd1,
    ST_PAUSE      = 2'd2,
    ST_MATCH_OVER = 2'd3
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;

  localparam int                 SCORE_W   = 5;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 5'd31;

endpackage

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: free-running frame counter, 0..FRAME_DIV-1.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset (count returns to 0)
//   tick - high for the one cycle where count == FRAME_DIV-1
module frame_tick_gen #(
  parameter int FRAME_DIV = 833333
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = $clog2(FRAME_DIV);
  localparam logic [CW-1:0] LAST = CW'(FRAME_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/game_referee.sv
// game_referee: match-level controller in front of the physics engine.
// Issues one phys_en per frame while playing, accepts the frame result the
// cycle after, keeps both scores, freezes play for PAUSE_FRAMES frames after
// each point and holds the match result until the next start.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start               - begin a match (honoured in IDLE / MATCH_OVER only)
//   phys_en             - one-cycle physics update enable
//   phys_valid          - physics result valid
//   phys_game_over      - ball hit the floor this frame
//   phys_winner         - 0 none, 1 P1, 2 P2, 3 reserved
//   freeze              - high whenever not in PLAY
//   p1_score, p2_score  - saturating scores
//   last_scorer         - most recent scorer (0 none)
//   point_pulse         - one cycle per awarded point
//   match_over          - high in MATCH_OVER
//   match_winner        - 0 until decided, then 1 or 2
//   state               - IDLE=0, PLAY=1, PAUSE=2, MATCH_OVER=3
//
// Build option: define GAME_REFEREE_DEUCE_EN for the win-by-two rule
// (scorer >= WIN_SCORE and leading by 2, or any score reaching 31).
// Without it the match ends when the scorer reaches exactly WIN_SCORE.
module game_referee
  import game_pkg::*;
#(
  parameter int FRAME_DIV    = 833333,
  parameter int PAUSE_FRAMES = 60,
  parameter int WIN_SCORE    = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               phys_en,
  input  logic               phys_valid,
  input  logic               phys_game_over,
  input  logic [1:0]         phys_winner,
  output logic               freeze,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [1:0]         last_scorer,
  output logic               point_pulse,
  output logic               match_over,
  output logic [1:0]         match_winner,
  output logic [1:0]         state
);

  localparam int                 PW  = $clog2(PAUSE_FRAMES + 1);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

  state_t         st;
  logic           tick;
  logic           outstanding;
  logic [PW-1:0]  pause_cnt;

  logic               accept;
  logic               point_p1;
  logic               point_p2;
  logic [SCORE_W-1:0] p1_inc;
  logic [SCORE_W-1:0] p2_inc;
  logic               ends_now;

  frame_tick_gen #(.FRAME_DIV(FRAME_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Match-end test on the scorer's post-increment score.
  function automatic logic match_ends(input logic [SCORE_W-1:0] s,
                                      input logic [SCORE_W-1:0] o);
`ifdef GAME_REFEREE_DEUCE_EN
    return ((s >= WIN) && ({1'b0, s} >= ({1'b0, o} + 6'd2))) || (s == SCORE_MAX);
`else
    return (s == WIN);
`endif
  endfunction

  // phys_en follows the frame tick directly so it lands in the tick cycle.
  assign phys_en  = tick && (st == ST_PLAY);
  assign accept   = phys_valid && outstanding && (st == ST_PLAY);
  assign point_p1 = accept && phys_game_over && (phys_winner == WIN_P1);
  assign point_p2 = accept && phys_game_over && (phys_winner == WIN_P2);
  assign p1_inc   = (p1_score == SCORE_MAX) ? SCORE_MAX : p1_score + 1'b1;
  assign p2_inc   = (p2_score == SCORE_MAX) ? SCORE_MAX : p2_score + 1'b1;
  assign ends_now = point_p1 ? match_ends(p1_inc, p2_score)
                             : match_ends(p2_inc, p1_score);

  assign state      = st;
  assign freeze     = (st != ST_PLAY);
  assign match_over = (st == ST_MATCH_OVER);

  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= ST_IDLE;
      outstanding  <= 1'b0;
      pause_cnt    <= '0;
      p1_score     <= '0;
      p2_score     <= '0;
      last_scorer  <= WIN_NONE;
      match_winner <= WIN_NONE;
      point_pulse  <= 1'b0;
    end else begin
      point_pulse <= 1'b0;
      case (st)
        ST_IDLE, ST_MATCH_OVER: begin
          outstanding <= 1'b0;
          if (start) begin
            p1_score     <= '0;
            p2_score     <= '0;
            last_scorer  <= WIN_NONE;
            match_winner <= WIN_NONE;
            st           <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (phys_en) begin
            outstanding <= 1'b1;
          end else if (accept) begin
            outstanding <= 1'b0;
          end
          if (point_p1 || point_p2) begin
            point_pulse <= 1'b1;
            outstanding <= 1'b0;
            if (point_p1) begin
              p1_score    <= p1_inc;
              last_scorer <= WIN_P1;
            end else begin
              p2_score    <= p2_inc;
              last_scorer <= WIN_P2;
            end
            if (ends_now) begin
              st           <= ST_MATCH_OVER;
              match_winner <= point_p1 ? WIN_P1 : WIN_P2;
            end else begin
              st        <= ST_PAUSE;
              pause_cnt <= PW'(PAUSE_FRAMES);
            end
          end
        end
        ST_PAUSE: begin
          outstanding <= 1'b0;
          if (tick) begin
            if (pause_cnt <= PW'(1)) begin
              pause_cnt <= '0;
              st        <= ST_PLAY;
            end else begin
              pause_cnt <= pause_cnt - 1'b1;
            end
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_referee.sv
module tb_game_referee;

  logic       clk = 1'b0;
  logic       rst, start, phys_en, phys_valid, phys_game_over;
  logic [1:0] phys_winner, last_scorer, match_winner, state;
  logic [4:0] p1_score, p2_score;
  logic       freeze, point_pulse, match_over;

  int checks = 0;
  int errors = 0;

  game_referee #(.FRAME_DIV(4), .PAUSE_FRAMES(3), .WIN_SCORE(3)) dut (
    .clk(clk), .rst(rst), .start(start), .phys_en(phys_en),
    .phys_valid(phys_valid), .phys_game_over(phys_game_over),
    .phys_winner(phys_winner), .freeze(freeze), .p1_score(p1_score),
    .p2_score(p2_score), .last_scorer(last_scorer), .point_pulse(point_pulse),
    .match_over(match_over), .match_winner(match_winner), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       go;
    logic [1:0] win;
    int         p1, p2, st, last, pulse, mw;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one cycle; sample/drive 1 time unit after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_en(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (phys_en) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) chk("phys_en_timeout", 0, 1);
  endtask

  // Physics echo: result arrives the cycle after phys_en; returns at N+2.
  task automatic echo(input logic go, input logic [1:0] w);
    bit ok;
    wait_en(ok);
    step();
    phys_valid = 1'b1; phys_game_over = go; phys_winner = w;
    step();
    phys_valid = 1'b0; phys_game_over = 1'b0; phys_winner = 2'd0;
  endtask

  task automatic wait_play();
    int n;
    n = 0;
    while (state != 2'd1 && n < 60) begin
      step();
      n++;
    end
    if (state != 2'd1) chk("wait_play_timeout", state, 1);
  endtask

  task automatic score_point(input logic [1:0] w);
    echo(1'b1, w);
    if (state == 2'd2) wait_play();
  endtask

  task automatic restart();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int  cnt, bad;
    bit  ok;

    vecs[0] = '{go:1'b1, win:2'd2, p1:0, p2:1, st:2, last:2, pulse:1, mw:0};
    vecs[1] = '{go:1'b0, win:2'd1, p1:0, p2:1, st:1, last:2, pulse:0, mw:0};
    vecs[2] = '{go:1'b1, win:2'd3, p1:0, p2:1, st:1, last:2, pulse:0, mw:0};
    vecs[3] = '{go:1'b1, win:2'd0, p1:0, p2:1, st:1, last:2, pulse:0, mw:0};
    vecs[4] = '{go:1'b1, win:2'd1, p1:1, p2:1, st:2, last:1, pulse:1, mw:0};
    vecs[5] = '{go:1'b1, win:2'd1, p1:2, p2:1, st:2, last:1, pulse:1, mw:0};
    vecs[6] = '{go:1'b1, win:2'd1, p1:3, p2:1, st:3, last:1, pulse:1, mw:1};

    rst = 1'b1; start = 1'b0; phys_valid = 1'b0;
    phys_game_over = 1'b0; phys_winner = 2'd0;
    repeat (3) step();
    chk("reset_state", state, 0);
    chk("reset_freeze", freeze, 1);
    chk("reset_pulse", point_pulse, 0);
    chk("reset_match_over", match_over, 0);
    rst = 1'b0;

    // Idle: nothing happens for 20 cycles.
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (phys_en || state != 2'd0 || !freeze || p1_score != 0 || p2_score != 0) bad++;
    end
    chk("idle_quiet", bad, 0);

    restart();
    chk("start_state", state, 1);
    chk("start_freeze", freeze, 0);

    // Stray valid with nothing outstanding must be ignored.
    phys_valid = 1'b1; phys_game_over = 1'b1; phys_winner = 2'd1;
    step();
    phys_valid = 1'b0; phys_game_over = 1'b0; phys_winner = 2'd0;
    chk("stray_valid_p1", p1_score, 0);
    chk("stray_valid_state", state, 1);
    chk("stray_valid_pulse", point_pulse, 0);

    // phys_en period.
    wait_en(ok);
    for (int k = 0; k < 2; k++) begin
      cnt = 0;
      do begin
        step();
        cnt++;
      end while (!phys_en && cnt < 20);
      chk("phys_en_period", cnt, 4);
    end

    // Table-driven frame results.
    for (int i = 0; i < 7; i++) begin
      echo(vecs[i].go, vecs[i].win);
      chk($sformatf("v%0d_p1", i), p1_score, vecs[i].p1);
      chk($sformatf("v%0d_p2", i), p2_score, vecs[i].p2);
      chk($sformatf("v%0d_state", i), state, vecs[i].st);
      chk($sformatf("v%0d_last", i), last_scorer, vecs[i].last);
      chk($sformatf("v%0d_pulse", i), point_pulse, vecs[i].pulse);
      chk($sformatf("v%0d_mwin", i), match_winner, vecs[i].mw);
      chk($sformatf("v%0d_freeze", i), freeze, (vecs[i].st != 1) ? 1 : 0);
      chk($sformatf("v%0d_mover", i), match_over, (vecs[i].st == 3) ? 1 : 0);
      step();
      chk($sformatf("v%0d_pulse_width", i), point_pulse, 0);
      if (vecs[i].st == 2) begin
        // Entry at N+2; ticks at N+4, N+8, N+12; PLAY at N+13.
        cnt = 1; bad = 0;
        while (state != 2'd1 && cnt < 50) begin
          if (phys_en) bad++;
          step();
          cnt++;
        end
        chk($sformatf("v%0d_pause_len", i), cnt, 11);
        chk($sformatf("v%0d_pause_no_en", i), bad, 0);
      end
    end

    // Match over: phys_en stays off, scores held.
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (phys_en) bad++;
      step();
    end
    chk("over_no_en", bad, 0);
    chk("over_p1_held", p1_score, 3);
    start = 1'b1;
    chk("over_start_ignored_yet", state, 3);
    step();
    start = 1'b0;
    chk("restart_state", state, 1);
    chk("restart_p1", p1_score, 0);
    chk("restart_p2", p2_score, 0);
    chk("restart_mwin", match_winner, 0);
    chk("restart_last", last_scorer, 0);

    // start during PLAY is ignored.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_in_play", state, 1);

`ifdef GAME_REFEREE_DEUCE_EN
    score_point(2'd1); score_point(2'd2); score_point(2'd1);
    score_point(2'd2); score_point(2'd1); score_point(2'd2);
    chk("deuce_33_p1", p1_score, 3);
    chk("deuce_33_p2", p2_score, 3);
    echo(1'b1, 2'd1);
    chk("deuce_43_state", state, 2);
    chk("deuce_43_mover", match_over, 0);
    wait_play();
    echo(1'b1, 2'd1);
    chk("deuce_53_p1", p1_score, 5);
    chk("deuce_53_state", state, 3);
    chk("deuce_53_mwin", match_winner, 1);
    restart();
`endif

    // Reset colliding with an accepted P2 point.
    score_point(2'd2);
    chk("pre_rst_p2", p2_score, 1);
    wait_en(ok);
    step();
    phys_valid = 1'b1; phys_game_over = 1'b1; phys_winner = 2'd2; rst = 1'b1;
    step();
    phys_valid = 1'b0; phys_game_over = 1'b0; phys_winner = 2'd0; rst = 1'b0;
    chk("rst_clash_p2", p2_score, 0);
    chk("rst_clash_state", state, 0);
    chk("rst_clash_pulse", point_pulse, 0);
    chk("rst_clash_last", last_scorer, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
